get_pixel: RTL and testbench
============================

# get_pixel

Nios II custom-instruction block that reads one 32-bit pixel from the VGA frame buffer, the read-side counterpart of the pixel-write instruction. It takes packed signed (x, y) coordinates in dataa and a fallback colour in datab, bounds-checks them, and computes the linear address y*H_RES + x. It then issues a single read on the frame-buffer port, waits for the returned word, and hands it back on result with a one-cycle done pulse. It sits between the CPU custom-instruction slot and the frame-buffer arbiter's read port.

## Interface
- H_RES, 640, horizontal resolution; valid x is 0..H_RES-1
- V_RES, 480, vertical resolution; valid y is 0..V_RES-1
- ADDR_W, 19, frame-buffer word-address width
- TIMEOUT, 1023, max cycles to wait for rdvalid before aborting
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- clk_en  in  1  custom-instruction clock enable; gates the FSM
- start  in  1  custom-instruction start, sampled only in IDLE with clk_en=1
- dataa  in  32  [15:0] signed x, [31:16] signed y
- datab  in  32  fallback colour, returned on out-of-range or timeout
- done  out  1  one-cycle completion pulse
- result  out  32  pixel read, or fallback colour
- addr  out  ADDR_W  frame-buffer word address
- rd  out  1  one-cycle read request
- busy  in  1  arbiter busy; rd is issued only when busy=0
- rdata  in  32  read data
- rdvalid  in  1  rdata valid strobe, single cycle, at least 1 cycle after rd

## Operation
- States: IDLE, REQ, WAIT_DATA, FINISH.
- IDLE: on start=1 with clk_en=1:
  - latch x, y and datab
  - if 0<=x<H_RES and 0<=y<V_RES (signed compare), go to REQ
  - otherwise load result<=datab and go to FINISH
- REQ: while busy=1, hold. When busy=0:
  - addr <= y*H_RES + x, truncated to ADDR_W bits; x and y are non-negative here
  - rd <= 1 for exactly one cycle
  - clear the timeout counter and go to WAIT_DATA
- WAIT_DATA:
  - rdvalid=1: result <= rdata, go to FINISH.
  - No rdvalid after TIMEOUT cycles: result <= latched datab, go to FINISH.
- FINISH: done <= 1 for one cycle, then IDLE.
- FSM transitions, rd and done are gated by clk_en; with clk_en=0 all state holds and rd/done are 0.
- rdvalid/rdata capture is NOT gated by clk_en. A rdvalid in WAIT_DATA is held in a pending flag plus data register and consumed at the next clk_en cycle.
- rdvalid outside WAIT_DATA is ignored, including late returns after a timeout.
- start outside IDLE is ignored.
- result holds its value until the next completion.
- addr holds its last issued value.

## Timing
- Reset (asynchronous): state=IDLE, done=0, rd=0, addr=0, result=0, pending flag and counter cleared.
- Reset mid-transaction aborts it; no done is produced.
- Out-of-range request: start sampled at edge E0, done=1 in the cycle after E1 (latency 1).
- In-range request, busy=0, rdvalid 1 cycle after rd:
  - rd=1 in the cycle after E1
  - rdvalid sampled at E2
  - done=1 in the cycle after E3 (latency 3)
- Each busy cycle in REQ adds 1 cycle of latency. Each cycle of rdvalid delay beyond the first adds 1 cycle.
- rdvalid and timeout expiry in the same cycle: rdvalid wins and result=rdata.
- The timeout counter counts only clk_en cycles. done asserts TIMEOUT+2 cycles after rd.
- Back-to-back: a new start is accepted in the first IDLE cycle after done.

## Test plan
- Reset, then x=10, y=2, busy=0, rdata=0x00FF00FF returned 1 cycle after rd -> addr=1290, single rd pulse, done 3 cycles after start, result=0x00FF00FF.
- x=639, y=479 with busy=1 for 4 cycles -> rd held off until busy=0, addr=307199, latency 7.
- x=-1 (0xFFFF) and, separately, x=640 or y=480, with datab=0xDEADBEEF -> no rd ever, done 1 cycle after start, result=0xDEADBEEF.
- Valid request, rdvalid never asserted, TIMEOUT=8 -> result=datab, done at rd+10. A later rdvalid with rdata=0x12345678 leaves result unchanged.
- clk_en=0 for 3 cycles while rdvalid pulses in WAIT_DATA -> data preserved, done on the first clk_en cycle after re-enable, result correct.
- Assert reset while in WAIT_DATA -> all outputs 0 immediately. A subsequent rdvalid is ignored, and the next start completes normally.

Source files
------------

// File: rtl/get_pixel.sv
// Custom-instruction pixel read: bounds-checks (x, y), issues one frame-buffer read,
// and returns the pixel (or the fallback colour) with a one-cycle done pulse.
module get_pixel #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic              done,
    output logic [31:0]       result,
    output logic [ADDR_W-1:0] addr,
    output logic              rd,
    input  logic              busy,
    input  logic [31:0]       rdata,
    input  logic              rdvalid
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitData,
        StFinish
    } state_t;

    state_t            r_state;
    logic [15:0]       r_x;
    logic [15:0]       r_y;
    logic [31:0]       r_fallback;
    logic [31:0]       r_pdata;
    logic              r_pend;
    logic [CNT_W-1:0]  r_cnt;

    logic signed [31:0] w_xs;
    logic signed [31:0] w_ys;
    logic               w_in_range;
    logic [31:0]        w_lin;

    assign w_xs       = 32'($signed(dataa[15:0]));
    assign w_ys       = 32'($signed(dataa[31:16]));
    assign w_in_range = (w_xs >= 0) && (w_xs < H_RES) && (w_ys >= 0) && (w_ys < V_RES);
    // Latched coordinates are known non-negative once a request reaches StReq.
    assign w_lin      = 32'(r_y) * 32'(H_RES) + 32'(r_x);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_x        <= '0;
            r_y        <= '0;
            r_fallback <= '0;
            r_pdata    <= '0;
            r_pend     <= 1'b0;
            r_cnt      <= '0;
            done       <= 1'b0;
            rd         <= 1'b0;
            addr       <= '0;
            result     <= '0;
        end else begin
            rd   <= 1'b0;
            done <= 1'b0;

            // Read returns arrive on the arbiter's schedule, not the CPU's clock enable.
            if (r_state == StWaitData && rdvalid && !clk_en) begin
                r_pend  <= 1'b1;
                r_pdata <= rdata;
            end

            if (clk_en) begin
                case (r_state)
                    StIdle: begin
                        if (start) begin
                            r_x        <= dataa[15:0];
                            r_y        <= dataa[31:16];
                            r_fallback <= datab;
                            if (w_in_range) begin
                                r_state <= StReq;
                            end else begin
                                result  <= datab;
                                r_state <= StFinish;
                            end
                        end
                    end
                    StReq: begin
                        if (!busy) begin
                            addr    <= w_lin[ADDR_W-1:0];
                            rd      <= 1'b1;
                            r_cnt   <= '0;
                            r_pend  <= 1'b0;
                            r_state <= StWaitData;
                        end
                    end
                    StWaitData: begin
                        if (rdvalid) begin
                            result  <= rdata;
                            r_pend  <= 1'b0;
                            r_state <= StFinish;
                        end else if (r_pend) begin
                            result  <= r_pdata;
                            r_pend  <= 1'b0;
                            r_state <= StFinish;
                        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                            result  <= r_fallback;
                            r_state <= StFinish;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    StFinish: begin
                        done    <= 1'b1;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_get_pixel.sv
// Bench for get_pixel: directed corner cases plus randomized requests checked against
// an arithmetic latency/result model.
module tb_get_pixel;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int AW = 19;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          start;
    logic [31:0]   dataa;
    logic [31:0]   datab;
    logic          done;
    logic [31:0]   result;
    logic [AW-1:0] addr;
    logic          rd;
    logic          busy;
    logic [31:0]   rdata;
    logic          rdvalid;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [31:0]   exp_result = '0;

    always #5 clk = ~clk;

    get_pixel #(
        .H_RES  (H),
        .V_RES  (V),
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
        .done   (done),
        .result (result),
        .addr   (addr),
        .rd     (rd),
        .busy   (busy),
        .rdata  (rdata),
        .rdvalid(rdvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request. Edge 0 samples start; busy is high for edges 1..nbusy; the read
    // return is sampled dly edges after the edge that raised rd (dly=0: never).
    task automatic run_txn(input int x, input int y, input logic [31:0] fb, input int nbusy,
                           input int dly, input logic [31:0] data, input bit quick);
        int t_rd;
        int t_done;
        int n_rd;
        int n_done;
        int exp_trd;
        int exp_tdone;
        bit inr;
        t_rd   = -1;
        t_done = -1;
        n_rd   = 0;
        n_done = 0;
        inr = (x >= 0) && (x < H) && (y >= 0) && (y < V);
        if (inr) begin
            exp_trd  = 1 + nbusy;
            exp_addr = AW'(y * H + x);
            if (dly >= 1 && dly <= TO + 1) begin
                exp_result = data;
                exp_tdone  = exp_trd + dly + 1;
            end else begin
                exp_result = fb;
                exp_tdone  = exp_trd + TO + 2;
            end
        end else begin
            exp_trd    = -1;
            exp_result = fb;
            exp_tdone  = 1;
        end

        dataa = {y[15:0], x[15:0]};
        datab = fb;
        start = 1'b1;
        busy  = (nbusy > 0);
        tick();
        start = 1'b0;
        for (int t = 0; t < 24; t++) begin
            busy    = (t + 1 <= nbusy);
            rdvalid = (t_rd >= 0) && (dly > 0) && (t + 1 == t_rd + dly);
            rdata   = rdvalid ? data : $urandom;
            tick();
            if (rd === 1'b1) begin
                n_rd++;
                if (t_rd < 0) t_rd = t + 1;
            end
            if (done === 1'b1) begin
                n_done++;
                if (t_done < 0) t_done = t + 1;
            end
            if (quick && n_done > 0) break;
        end
        rdvalid = 1'b0;
        busy    = 1'b0;

        check("rd_count", 32'(n_rd), inr ? 32'd1 : 32'd0);
        check("rd_time", 32'(t_rd), 32'(exp_trd));
        check("addr", 32'(addr), 32'(exp_addr));
        check("done_time", 32'(t_done), 32'(exp_tdone));
        check("done_count", 32'(n_done), 32'd1);
        check("result", result, exp_result);
    endtask

    initial begin
        int x;
        int y;
        int sel;
        int n_done;
        reset   = 1'b1;
        clk_en  = 1'b1;
        start   = 1'b0;
        dataa   = '0;
        datab   = '0;
        busy    = 1'b0;
        rdata   = '0;
        rdvalid = 1'b0;
        tick();
        tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b0;
        tick();

        // Directed scenarios
        run_txn(10, 2, 32'h0BAD_0BAD, 0, 1, 32'h00FF_00FF, 1'b0);
        check("addr_1290", 32'(addr), 32'd1290);
        run_txn(H - 1, V - 1, 32'h1111_2222, 4, 1, 32'hA5A5_5A5A, 1'b0);
        check("addr_max", 32'(addr), 32'd307199);
        run_txn(-1, 5, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
        run_txn(H, 5, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
        run_txn(5, V, 32'hDEAD_BEEF, 0, 1, 32'h0, 1'b0);
        run_txn(0, 0, 32'hFA11_BAC4, 0, 0, 32'h0, 1'b0);
        run_txn(20, 20, 32'hFA11_BAC5, 1, TO + 3, 32'h1234_5678, 1'b0);
        run_txn(21, 20, 32'hFA11_BAC6, 0, TO + 1, 32'h7777_0001, 1'b0);
        run_txn(22, 20, 32'hFA11_BAC7, 0, TO + 2, 32'h7777_0002, 1'b0);
        // Back-to-back starts in the first idle cycle after done
        run_txn(30, 3, 32'h0000_0001, 0, 2, 32'hB2B0_0001, 1'b1);
        run_txn(-7, 3, 32'h0000_0002, 0, 1, 32'h0, 1'b1);
        run_txn(31, 3, 32'h0000_0003, 2, 1, 32'hB2B0_0003, 1'b1);

        // Read return while the clock enable is low is held until re-enable
        dataa = {16'd5, 16'd7};
        datab = 32'hFEED_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ce_rd", 32'(rd), 32'd1);
        clk_en  = 1'b0;
        rdvalid = 1'b1;
        rdata   = 32'hCAFE_0001;
        tick();
        rdvalid = 1'b0;
        rdata   = 32'h0;
        check("ce_hold_done", 32'(done), 32'd0);
        tick();
        tick();
        check("ce_hold_done2", 32'(done), 32'd0);
        clk_en = 1'b1;
        n_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("ce_done_count", 32'(n_done), 32'd1);
        check("ce_result", result, 32'hCAFE_0001);
        check("ce_addr", 32'(addr), 32'd3207);

        // Reset while waiting for data aborts the request
        dataa = {16'd1, 16'd3};
        datab = 32'h5555_AAAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_rd", 32'(rd), 32'd0);
        check("rst_mid_addr", 32'(addr), 32'd0);
        check("rst_mid_result", result, 32'd0);
        tick();
        reset      = 1'b0;
        exp_addr   = '0;
        rdvalid    = 1'b1;
        rdata      = 32'h0BAD_DA7A;
        tick();
        rdvalid = 1'b0;
        n_done  = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("rst_late_done", 32'(n_done), 32'd0);
        check("rst_late_result", result, 32'd0);
        run_txn(3, 1, 32'h5555_AAAA, 0, 1, 32'h0600_D000, 1'b0);

        // Randomized requests
        for (int k = 0; k < 30; k++) begin
            x   = int'($urandom_range(0, H - 1));
            y   = int'($urandom_range(0, V - 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0) x = -int'($urandom_range(1, 100));
            if (sel == 1) x = H + int'($urandom_range(0, 50));
            if (sel == 2) y = V + int'($urandom_range(0, 30));
            if (sel == 3) y = -1;
            run_txn(x, y, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, TO + 3)),
                    $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
